// File: rtl/cordic_phase_frontend.sv
// cordic_phase_frontend: full-circle phase reduction, CORDIC core handshake and quadrant correction
module cordic_phase_frontend #(
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        phase_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] cos_out,
    output logic signed [15:0] sin_out,
    output logic               err,
    output logic               core_start,
    output logic signed [15:0] core_angle,
    input  logic signed [15:0] core_cos,
    input  logic signed [15:0] core_sin,
    input  logic               core_valid
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, OUTPUT} state_t;

    state_t             state;
    logic [1:0]         q;
    logic [1:0]         qs;
    logic [CW-1:0]      cnt;
    logic signed [15:0] c_in, s_in, c_fix, s_fix;

    function automatic logic signed [15:0] neg(input logic signed [15:0] v);
        return (v == 16'sh8000) ? 16'sh7FFF : -v;
    endfunction

    assign in_ready  = state == IDLE;
    assign out_valid = state == OUTPUT;

    // One correction path serves the bypass, the core result and the timeout zero.
    always_comb begin
        qs    = (state == IDLE) ? phase_in[15:14] : q;
        c_in  = (state == IDLE) ? 16'sh7FFF : (core_valid ? core_cos : 16'sh0000);
        s_in  = (state == IDLE) ? 16'sh0000 : (core_valid ? core_sin : 16'sh0000);
        c_fix = (qs == 2'd0) ? c_in : (qs == 2'd1) ? neg(s_in) : (qs == 2'd2) ? neg(c_in) : s_in;
        s_fix = (qs == 2'd0) ? s_in : (qs == 2'd1) ? c_in : (qs == 2'd2) ? neg(s_in) : neg(c_in);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            q          <= '0;
            cnt        <= '0;
            cos_out    <= '0;
            sin_out    <= '0;
            err        <= 1'b0;
            core_start <= 1'b0;
            core_angle <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    q <= phase_in[15:14];
                    if (phase_in[13:0] == 14'd0) begin
                        cos_out <= c_fix;
                        sin_out <= s_fix;
                        state   <= OUTPUT;
                    end else begin
                        core_angle <= {1'b0, phase_in[13:0], 1'b0};
                        core_start <= 1'b1;
                        cnt        <= '0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: if (core_valid) begin
                    cos_out    <= c_fix;
                    sin_out    <= s_fix;
                    core_start <= 1'b0;
                    state      <= RELEASE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    cos_out    <= c_fix;
                    sin_out    <= s_fix;
                    err        <= 1'b1;
                    core_start <= 1'b0;
                    state      <= OUTPUT;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                // Wait for the core to drop valid so the next issue never sees a stale result.
                RELEASE: if (!core_valid) state <= OUTPUT;
                OUTPUT: if (out_ready) begin
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_phase_frontend.sv
// tb_cordic_phase_frontend: directed checks of bypass, core path, saturation, timeout, stall and reset
module tb_cordic_phase_frontend;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [15:0]        phase_in = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [15:0] cos_out, sin_out;
    logic               err;
    logic               core_start;
    logic signed [15:0] core_angle;
    logic signed [15:0] core_cos = '0;
    logic signed [15:0] core_sin = '0;
    logic               core_valid = 1'b0;

    int checks = 0;
    int errors = 0;

    cordic_phase_frontend #(.TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .phase_in(phase_in),
        .out_valid(out_valid), .out_ready(out_ready), .cos_out(cos_out), .sin_out(sin_out),
        .err(err), .core_start(core_start), .core_angle(core_angle), .core_cos(core_cos),
        .core_sin(core_sin), .core_valid(core_valid)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [15:0] p);
        in_valid = 1'b1;
        phase_in = p;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL reset_core_start got %b exp 0", core_start); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        checks++; if ({cos_out, sin_out, core_angle} !== 48'h0) begin errors++; $display("FAIL reset_data got %h exp 0", {cos_out, sin_out, core_angle}); end
    endtask

    task automatic test_bypass(input logic [15:0] p, input logic [15:0] ec, input logic [15:0] es);
        accept(p);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid %h got %b exp 1", p, out_valid); end
        checks++; if (cos_out !== ec) begin errors++; $display("FAIL bypass_cos %h got %h exp %h", p, cos_out, ec); end
        checks++; if (sin_out !== es) begin errors++; $display("FAIL bypass_sin %h got %h exp %h", p, sin_out, es); end
        checks++; if ({err, core_start, in_ready} !== 3'b000) begin errors++; $display("FAIL bypass_flags %h got %b exp 000", p, {err, core_start, in_ready}); end
        drain();
        checks++; if ({in_ready, out_valid, core_start} !== 3'b100) begin errors++; $display("FAIL bypass_done %h got %b exp 100", p, {in_ready, out_valid, core_start}); end
    endtask

    task automatic test_core(input logic [15:0] p, input logic [15:0] ea, input int dly,
                             input logic [15:0] c, input logic [15:0] s,
                             input logic [15:0] ec, input logic [15:0] es);
        accept(p);
        checks++; if ({core_start, in_ready, out_valid} !== 3'b100) begin errors++; $display("FAIL core_issue %h got %b exp 100", p, {core_start, in_ready, out_valid}); end
        checks++; if (core_angle !== ea) begin errors++; $display("FAIL core_angle %h got %h exp %h", p, core_angle, ea); end
        for (int i = 0; i < dly; i++) tick();
        checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL core_hold %h got %b exp 1", p, core_start); end
        core_valid = 1'b1;
        core_cos   = c;
        core_sin   = s;
        tick();
        checks++; if ({core_start, out_valid} !== 2'b00) begin errors++; $display("FAIL core_release %h got %b exp 00", p, {core_start, out_valid}); end
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL core_stale %h got %b exp 0", p, out_valid); end
        core_valid = 1'b0;
        core_cos   = 16'h5555;
        core_sin   = 16'h5555;
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL core_valid_out %h got %b exp 1", p, out_valid); end
        checks++; if (cos_out !== ec) begin errors++; $display("FAIL core_cos %h got %h exp %h", p, cos_out, ec); end
        checks++; if (sin_out !== es) begin errors++; $display("FAIL core_sin %h got %h exp %h", p, sin_out, es); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL core_err %h got %b exp 0", p, err); end
        drain();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL core_done %h got %b exp 1", p, in_ready); end
    endtask

    task automatic test_timeout;
        accept(16'h6000);
        for (int i = 0; i < 63; i++) tick();
        checks++; if ({out_valid, core_start} !== 2'b01) begin errors++; $display("FAIL timeout_early got %b exp 01", {out_valid, core_start}); end
        tick();
        checks++; if ({out_valid, err, core_start} !== 3'b110) begin errors++; $display("FAIL timeout_flags got %b exp 110", {out_valid, err, core_start}); end
        checks++; if ({cos_out, sin_out} !== 32'h0) begin errors++; $display("FAIL timeout_data got %h exp 0", {cos_out, sin_out}); end
        drain();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL timeout_err_clear got %b exp 0", err); end
        test_core(16'h2000, 16'h4000, 5, 16'h5A82, 16'h5A82, 16'h5A82, 16'h5A82);
    endtask

    task automatic test_stall;
        logic [31:0] held;
        accept(16'hC000);
        held = {cos_out, sin_out};
        checks++; if (held !== 32'h0000_8001) begin errors++; $display("FAIL stall_data got %h exp 00008001", held); end
        in_valid = 1'b1;
        phase_in = 16'h4000;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if ({out_valid, in_ready, cos_out, sin_out} !== {2'b10, held}) begin errors++; $display("FAIL stall_hold %0d got %h exp %h", i, {out_valid, in_ready, cos_out, sin_out}, {2'b10, held}); end
        end
        in_valid = 1'b0;
        drain();
        checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL stall_done got %b exp 10", {in_ready, out_valid}); end
    endtask

    task automatic test_reset_in_issue;
        accept(16'h6000);
        tick();
        checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL rst_pre got %b exp 1", core_start); end
        rst = 1'b1;
        #2;
        checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL rst_async_start got %b exp 0", core_start); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if ({in_ready, out_valid, core_start} !== 3'b100) begin errors++; $display("FAIL rst_after got %b exp 100", {in_ready, out_valid, core_start}); end
        test_bypass(16'h0000, 16'h7FFF, 16'h0000);
    endtask

    initial begin
        test_reset();
        test_bypass(16'h0000, 16'h7FFF, 16'h0000);
        test_bypass(16'h4000, 16'h0000, 16'h7FFF);
        test_bypass(16'h8000, 16'h8001, 16'h0000);
        test_core(16'h6000, 16'h4000, 35, 16'h5A82, 16'h5A82, 16'hA57E, 16'h5A82);
        test_core(16'hA000, 16'h4000, 3, 16'h8000, 16'h1234, 16'h7FFF, 16'hEDCC);
        test_core(16'hE000, 16'h4000, 2, 16'h1111, 16'h2222, 16'h2222, 16'hEEEF);
        test_core(16'h0001, 16'h0002, 1, 16'h7FFF, 16'h0003, 16'h7FFF, 16'h0003);
        test_core(16'h7FFF, 16'h7FFE, 4, 16'h0001, 16'h8000, 16'h7FFF, 16'h0001);
        test_timeout();
        test_stall();
        test_reset_in_issue();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
